// File: rtl/lcd_message_arbiter.sv
// Arbitrates NUM_REQ message sources onto one 16x2 text LCD with timed holds.
// Define LCD_ARB_ROUND_ROBIN_EN for round-robin selection without preemption.
module lcd_message_arbiter #(
    parameter int           NUM_REQ    = 3,
    parameter int           HOLD_TICKS = 200,
    parameter int           MIN_TICKS  = 50,
    parameter logic [127:0] IDLE_LINE1 = "VENDING MACHINE ",
    parameter logic [127:0] IDLE_LINE2 = "INSERT COIN     "
) (
    input  logic                   clk_100hz,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*128-1:0] line1_in,
    input  logic [NUM_REQ*128-1:0] line2_in,
    input  logic [NUM_REQ*7-1:0]   cursor_in,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic [127:0]           line1_text,
    output logic [127:0]           line2_text,
    output logic [6:0]             ddram_address,
    output logic                   refresh
);

    localparam int CW = $clog2(HOLD_TICKS + 1);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHOW,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_done;
    logic [NUM_REQ-1:0]   r_served;
    logic [IW-1:0]        r_gIdx;
    logic [CW-1:0]        r_holdCnt;
    logic [127:0]         r_line1;
    logic [127:0]         r_line2;
    logic [6:0]           r_addr;
    logic                 r_refresh;
`ifdef LCD_ARB_ROUND_ROBIN_EN
    logic [IW-1:0]        r_lastDone;
`endif

    logic [NUM_REQ-1:0]   w_eligible;
    logic                 w_anyEligible;
    logic [IW-1:0]        w_winIdx;
    logic [NUM_REQ-1:0]   w_winOneHot;
    logic                 w_preempt;
    logic [127:0]         w_winLine1;
    logic [127:0]         w_winLine2;
    logic [6:0]           w_winAddr;
    logic [127:0]         w_curLine1;
    logic [127:0]         w_curLine2;
    logic [6:0]           w_curAddr;

    assign w_eligible = req & ~r_served;

    // A source that already had its showing stays out until it drops its request.
    always_comb begin
        w_anyEligible = 1'b0;
        w_winIdx      = '0;
`ifdef LCD_ARB_ROUND_ROBIN_EN
        for (int off = 0; off < NUM_REQ; off++) begin
            int idx;
            idx = (int'(r_lastDone) + 1 + off) % NUM_REQ;
            if (!w_anyEligible && w_eligible[idx]) begin
                w_anyEligible = 1'b1;
                w_winIdx      = IW'(idx);
            end
        end
`else
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_eligible[k]) begin
                w_anyEligible = 1'b1;
                w_winIdx      = IW'(k);
            end
        end
`endif
    end

    always_comb begin
        w_winOneHot           = '0;
        w_winOneHot[w_winIdx] = 1'b1;
    end

`ifdef LCD_ARB_ROUND_ROBIN_EN
    assign w_preempt = 1'b0;
`else
    assign w_preempt = w_anyEligible && (w_winIdx < r_gIdx) &&
                       (r_holdCnt >= CW'(MIN_TICKS));
`endif

    assign w_winLine1 = line1_in[int'(w_winIdx)*128 +: 128];
    assign w_winLine2 = line2_in[int'(w_winIdx)*128 +: 128];
    assign w_winAddr  = cursor_in[int'(w_winIdx)*7 +: 7];
    assign w_curLine1 = line1_in[int'(r_gIdx)*128 +: 128];
    assign w_curLine2 = line2_in[int'(r_gIdx)*128 +: 128];
    assign w_curAddr  = cursor_in[int'(r_gIdx)*7 +: 7];

    // Text outputs are loaded on the same edge as the grant so that the
    // banner is shown in IDLE/DONE and live source text while granted.
    always_ff @(posedge clk_100hz or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_done    <= '0;
            r_served  <= '0;
            r_gIdx    <= '0;
            r_holdCnt <= '0;
            r_line1   <= IDLE_LINE1;
            r_line2   <= IDLE_LINE2;
            r_addr    <= 7'h00;
            r_refresh <= 1'b0;
`ifdef LCD_ARB_ROUND_ROBIN_EN
            r_lastDone <= IW'(NUM_REQ - 1);
`endif
        end else begin
            r_done    <= '0;
            r_refresh <= 1'b0;
            r_served  <= r_served & req;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_holdCnt <= '0;
                    if (w_anyEligible) begin
                        r_state   <= S_SHOW;
                        r_gIdx    <= w_winIdx;
                        r_grant   <= w_winOneHot;
                        r_refresh <= 1'b1;
                        r_line1   <= w_winLine1;
                        r_line2   <= w_winLine2;
                        r_addr    <= w_winAddr;
                    end else begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_line1 <= IDLE_LINE1;
                        r_line2 <= IDLE_LINE2;
                        r_addr  <= 7'h00;
                    end
                end
                S_SHOW: begin
                    if (!req[r_gIdx] || w_preempt) begin
                        r_holdCnt <= '0;
                        r_refresh <= 1'b1;
                        if (w_anyEligible) begin
                            r_state <= S_SHOW;
                            r_gIdx  <= w_winIdx;
                            r_grant <= w_winOneHot;
                            r_line1 <= w_winLine1;
                            r_line2 <= w_winLine2;
                            r_addr  <= w_winAddr;
                        end else begin
                            r_state <= S_IDLE;
                            r_grant <= '0;
                            r_line1 <= IDLE_LINE1;
                            r_line2 <= IDLE_LINE2;
                            r_addr  <= 7'h00;
                        end
                    end else if (r_holdCnt == CW'(HOLD_TICKS - 1)) begin
                        r_state          <= S_DONE;
                        r_done           <= r_grant;
                        r_served[r_gIdx] <= 1'b1;
                        r_grant          <= '0;
                        r_holdCnt        <= '0;
                        r_refresh        <= 1'b1;
                        r_line1          <= IDLE_LINE1;
                        r_line2          <= IDLE_LINE2;
                        r_addr           <= 7'h00;
`ifdef LCD_ARB_ROUND_ROBIN_EN
                        r_lastDone       <= r_gIdx;
`endif
                    end else begin
                        if (r_holdCnt != CW'(HOLD_TICKS)) begin
                            r_holdCnt <= r_holdCnt + 1'b1;
                        end
                        r_line1 <= w_curLine1;
                        r_line2 <= w_curLine2;
                        r_addr  <= w_curAddr;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign grant         = r_grant;
    assign done          = r_done;
    assign line1_text    = r_line1;
    assign line2_text    = r_line2;
    assign ddram_address = r_addr;
    assign refresh       = r_refresh;

endmodule

// File: tb/tb_lcd_message_arbiter.sv
// Self-checking bench for lcd_message_arbiter: vector table, directed corner
// cases and random traffic against a behavioural display-ownership model.
module tb_lcd_message_arbiter;

    localparam int N    = 3;
    localparam int HOLD = 10;
    localparam int MINT = 4;
    localparam logic [127:0] BANNER1 = "VENDING MACHINE ";
    localparam logic [127:0] BANNER2 = "INSERT COIN     ";

    logic           clk_100hz = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*128-1:0] line1_in;
    logic [N*128-1:0] line2_in;
    logic [N*7-1:0] cursor_in;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic [127:0]   line1_text;
    logic [127:0]   line2_text;
    logic [6:0]     ddram_address;
    logic           refresh;

    int testCount = 0;
    int failCount = 0;

    // Model: which source owns the display (-1 = banner) and for how long.
    int           mCur;
    int           mAge;
    bit           mServed[N];
    logic [N-1:0] eGrant;
    logic [N-1:0] eDone;
    logic         eRefresh;
    logic [127:0] eL1;
    logic [127:0] eL2;
    logic [6:0]   eAddr;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] grant;
        logic [N-1:0] done;
        logic         refresh;
    } vec_t;
    vec_t vecs[13];

    lcd_message_arbiter #(
        .NUM_REQ   (N),
        .HOLD_TICKS(HOLD),
        .MIN_TICKS (MINT)
    ) dut (
        .clk_100hz    (clk_100hz),
        .rst          (rst),
        .req          (req),
        .line1_in     (line1_in),
        .line2_in     (line2_in),
        .cursor_in    (cursor_in),
        .grant        (grant),
        .done         (done),
        .line1_text   (line1_text),
        .line2_text   (line2_text),
        .ddram_address(ddram_address),
        .refresh      (refresh)
    );

    always #5 clk_100hz = ~clk_100hz;

    function automatic int lowestWaiting();
        for (int k = 0; k < N; k++) begin
            if (req[k] && !mServed[k]) return k;
        end
        return -1;
    endfunction

    task automatic setExpected(input int prev);
        eGrant   = '0;
        eL1      = BANNER1;
        eL2      = BANNER2;
        eAddr    = 7'h00;
        if (mCur >= 0) begin
            eGrant[mCur] = 1'b1;
            eL1   = line1_in[mCur*128 +: 128];
            eL2   = line2_in[mCur*128 +: 128];
            eAddr = cursor_in[mCur*7 +: 7];
        end
        eRefresh = (mCur != prev);
    endtask

    task automatic modelReset();
        mCur = -1;
        mAge = 0;
        for (int k = 0; k < N; k++) mServed[k] = 1'b0;
        eDone = '0;
        setExpected(-1);
    endtask

    task automatic modelStep();
        int prev;
        int w;
        int finished;
        prev     = mCur;
        finished = -1;
        eDone    = '0;
        w        = lowestWaiting();
        if (mCur < 0) begin
            if (w >= 0) begin
                mCur = w;
                mAge = 0;
            end
        end else if (!req[mCur]) begin
            mCur = w;
            mAge = 0;
        end else if (mAge == HOLD - 1) begin
            finished = mCur;
            eDone[mCur] = 1'b1;
            mCur = -1;
            mAge = 0;
        end else if (w >= 0 && w < mCur && mAge >= MINT) begin
            mCur = w;
            mAge = 0;
        end else begin
            mAge++;
        end
        for (int k = 0; k < N; k++) begin
            if (!req[k]) mServed[k] = 1'b0;
        end
        if (finished >= 0) mServed[finished] = 1'b1;
        setExpected(prev);
    endtask

    task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name);
        checkVal({name, ".grant"},   128'(grant),         128'(eGrant));
        checkVal({name, ".done"},    128'(done),          128'(eDone));
        checkVal({name, ".refresh"}, 128'(refresh),       128'(eRefresh));
        checkVal({name, ".line1"},   line1_text,          eL1);
        checkVal({name, ".line2"},   line2_text,          eL2);
        checkVal({name, ".ddram"},   128'(ddram_address), 128'(eAddr));
    endtask

    task automatic applyStimulus(input logic [N-1:0] r);
        req = r;
    endtask

    task automatic tick(input string name);
        @(posedge clk_100hz);
        modelStep();
        #1;
        checkOutput(name);
    endtask

    // Counts consecutive cycles with grant==g (current cycle included),
    // then expects a full hold followed by the done pulse for g.
    task automatic runHold(input logic [N-1:0] g, input string name);
        int n;
        n = 0;
        while (grant == g && n < 40) begin
            n++;
            tick(name);
        end
        checkVal({name, ".holdLen"}, 128'(n), 128'(HOLD));
        checkVal({name, ".donePulse"}, 128'(done), 128'(g));
    endtask

    initial begin
        logic [127:0] s0L1 = "PRODUCT MENU  A1";
        logic [127:0] s1L1 = "PRICE 1.50 EUR  ";
        logic [127:0] s2L1 = "ERROR: JAMMED   ";
        logic [127:0] s0L2 = "SELECT ITEM     ";
        logic [127:0] s1L2 = "PAID 0.50 EUR   ";
        logic [127:0] s2L2 = "CALL SERVICE    ";
        line1_in  = {s2L1, s1L1, s0L1};
        line2_in  = {s2L2, s1L2, s0L2};
        cursor_in = {7'h45, 7'h40, 7'h0A};
        req       = '0;
        rst       = 1'b0;
        modelReset();

        vecs[0] = '{req: 3'b010, grant: 3'b010, done: 3'b000, refresh: 1'b1};
        for (int i = 1; i <= 9; i++)
            vecs[i] = '{req: 3'b010, grant: 3'b010, done: 3'b000, refresh: 1'b0};
        vecs[10] = '{req: 3'b010, grant: 3'b000, done: 3'b010, refresh: 1'b1};
        vecs[11] = '{req: 3'b010, grant: 3'b000, done: 3'b000, refresh: 1'b0};
        vecs[12] = '{req: 3'b010, grant: 3'b000, done: 3'b000, refresh: 1'b0};

        #12;
        checkOutput("reset");
        #10;
        rst = 1'b1;
        repeat (4) tick("idle");

        // Single request, then held high without a second showing
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].req);
            tick("vecModel");
            checkVal($sformatf("vec%0d.grant", i),   128'(grant),   128'(vecs[i].grant));
            checkVal($sformatf("vec%0d.done", i),    128'(done),    128'(vecs[i].done));
            checkVal($sformatf("vec%0d.refresh", i), 128'(refresh), 128'(vecs[i].refresh));
            if (i == 1) checkVal("line1_cycle2", line1_text, s1L1);
            if (i == 11) checkVal("banner_after_done", line1_text, BANNER1);
        end
        applyStimulus(3'b000);
        repeat (2) tick("release");

        // Simultaneous requests: lowest index first, then the other with full hold
        applyStimulus(3'b110);
        tick("simul");
        checkVal("simul.first", 128'(grant), 128'(3'b010));
        runHold(3'b010, "simulSrc1");
        applyStimulus(3'b100);
        tick("simul2");
        checkVal("simul.second", 128'(grant), 128'(3'b100));
        runHold(3'b100, "simulSrc2");
        applyStimulus(3'b000);
        repeat (2) tick("release");

        // Preemption only after the minimum showing time
        applyStimulus(3'b100);
        repeat (3) tick("pre");
        applyStimulus(3'b101);
        tick("pre3");
        checkVal("pre.hold3", 128'(grant), 128'(3'b100));
        tick("pre4");
        checkVal("pre.hold4", 128'(grant), 128'(3'b100));
        tick("preSwitch");
        checkVal("pre.switch", 128'(grant), 128'(3'b001));
        checkVal("pre.refresh", 128'(refresh), 128'(1'b1));
        runHold(3'b001, "preSrc0");
        tick("regrant");
        checkVal("pre.regrant", 128'(grant), 128'(3'b100));
        runHold(3'b100, "preSrc2");
        applyStimulus(3'b000);
        repeat (2) tick("release");

        // Abort: request dropped mid-show
        applyStimulus(3'b010);
        repeat (6) tick("abort");
        applyStimulus(3'b000);
        tick("abortEdge");
        checkVal("abort.grant", 128'(grant), 128'(3'b000));
        checkVal("abort.done", 128'(done), 128'(3'b000));
        checkVal("abort.refresh", 128'(refresh), 128'(1'b1));

        // Asynchronous reset mid-message
        applyStimulus(3'b010);
        repeat (7) tick("rstMid");
        #2 rst = 1'b0;
        #1;
        modelReset();
        checkOutput("asyncReset");
        checkVal("asyncReset.grant", 128'(grant), 128'(3'b000));
        #2 rst = 1'b1;
        tick("afterReset");
        checkVal("afterReset.grant", 128'(grant), 128'(3'b010));

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                int k;
                k = $urandom_range(0, N - 1);
                req[k] = ~req[k];
            end
            if ($urandom_range(0, 7) == 0) begin
                int k;
                k = $urandom_range(0, N - 1);
                line1_in[k*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
                line2_in[k*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
                cursor_in[k*7 +: 7]    = 7'($urandom);
            end
            tick("random");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
